// File: rtl/disp_pkg.sv
// Shared definitions for the hood display arbiter: owner codes, glyph codes and 7-seg patterns.
package disp_pkg;

  typedef enum logic [1:0] {
    OWN_OFF     = 2'b00,
    OWN_CLOCK   = 2'b01,
    OWN_WORK    = 2'b10,
    OWN_GESTURE = 2'b11
  } own_t;

  localparam logic [3:0] GLY_DASH  = 4'hA;
  localparam logic [3:0] GLY_BLANK = 4'hB;

  // Segment order {dp,g,f,e,d,c,b,a}; entries 0-9 are digits, entry 10 is the dash.
  localparam logic [0:10][7:0] SEG_TABLE = {
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F,
    8'h40
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; codes at or above GLY_BLANK render dark.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = '0;
    if (code < GLY_BLANK) seg = SEG_TABLE[code];
  end

endmodule

// File: rtl/display_arbiter.sv
// Owner FSM with hold timeout plus digit scan for the shared 8-digit display.
// Optional hold-phase blinking is built only when DISPLAY_BLINK_EN is defined.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned HOLD_S  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power_state,
  input  logic        req_work,
  input  logic        req_gesture,
  input  logic        gesture_active,
  input  logic [31:0] src_clock,
  input  logic [31:0] src_work,
  input  logic [31:0] src_gesture,
  output logic [7:0]  seg_left,
  output logic [7:0]  seg_right,
  output logic [7:0]  dig_sel,
  output logic [1:0]  owner
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW       = $clog2(CLK_HZ);
  localparam int unsigned TW       = $clog2(HOLD_S + 1);

  own_t          state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [PW-1:0] sec_cnt, scan_cnt;
  logic [1:0]    idx, out_idx;
  logic          sec_tick, scan_wrap, restart, blank;
  logic [31:0]   src;
  logic [3:0]    nib_r, nib_l;
  logic [7:0]    glyph_r, glyph_l;

  assign owner     = state;
  assign sec_tick  = (sec_cnt == PW'(CLK_HZ - 1));
  assign scan_wrap = (scan_cnt == PW'(SCAN_DIV - 1));

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    if (!power_state) begin
      state_nx = OWN_OFF;
      timer_nx = '0;
    end else if (state == OWN_OFF) begin
      state_nx = OWN_CLOCK;
      timer_nx = '0;
    end else if (req_work && req_gesture) begin
      state_nx = OWN_CLOCK;
      timer_nx = '0;
    end else if (gesture_active || (req_gesture && !req_work)) begin
      state_nx = OWN_GESTURE;
      timer_nx = TW'(HOLD_S);
    end else if (req_work) begin
      state_nx = OWN_WORK;
      timer_nx = TW'(HOLD_S);
    end else if (state != OWN_CLOCK) begin
      if (timer == '0) state_nx = OWN_CLOCK;
      else if (sec_tick) timer_nx = timer - TW'(1);
    end
  end

  // Outputs follow the next owner so a new source starts cleanly at digit 0.
  assign restart = (state_nx != state) || (state_nx == OWN_OFF);
  assign out_idx = (state_nx != state) ? 2'd0 : idx;

  always_comb begin
    case (state_nx)
      OWN_CLOCK:   src = src_clock;
      OWN_WORK:    src = src_work;
      OWN_GESTURE: src = src_gesture;
      default:     src = '0;
    endcase
  end

  assign nib_r = src[{out_idx, 2'b00} +: 4];
  assign nib_l = src[{1'b1, out_idx, 2'b00} +: 4];

  seg7_decode u_dec_right (.code(nib_r), .seg(glyph_r));
  seg7_decode u_dec_left  (.code(nib_l), .seg(glyph_l));

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned BLINK_PER = CLK_HZ / 2;
  logic [PW-1:0] blink_cnt;
  logic          hold_ph;

  assign hold_ph = power_state && (state == OWN_WORK || state == OWN_GESTURE) &&
                   !req_work && !req_gesture && !gesture_active && (timer != '0);
  assign blank   = hold_ph && (blink_cnt >= PW'(BLINK_PER / 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              blink_cnt <= '0;
    else if (!hold_ph)                       blink_cnt <= '0;
    else if (blink_cnt == PW'(BLINK_PER - 1)) blink_cnt <= '0;
    else                                     blink_cnt <= blink_cnt + PW'(1);
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= OWN_OFF;
      timer     <= '0;
      sec_cnt   <= '0;
      scan_cnt  <= '0;
      idx       <= '0;
      dig_sel   <= '0;
      seg_left  <= '0;
      seg_right <= '0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      sec_cnt <= sec_tick ? '0 : sec_cnt + PW'(1);
      if (restart) begin
        scan_cnt <= '0;
        idx      <= '0;
      end else if (scan_wrap) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + PW'(1);
      end
      if (state_nx == OWN_OFF) begin
        dig_sel   <= '0;
        seg_left  <= '0;
        seg_right <= '0;
      end else begin
        dig_sel   <= blank ? 8'h00 : (8'h11 << out_idx);
        seg_left  <= glyph_l;
        seg_right <= glyph_r;
      end
    end
  end

endmodule
